vga_pattern_ctrl: RTL and testbench

Parametrised VGA controller for the Nexys 4 DDR display path; it supersedes the fixed 640x480 switch-colour top. It generates its own pixel tick and sync counters from the system clock, so no separate sync block is needed. It produces a registered RGB pattern chosen by a mode input: solid switch colour, colour bars, checkerboard, or a moving bar. Mode changes take effect only at frame boundaries, so a frame never shows two patterns.

---
 rtl/vga_pattern_ctrl.sv | 149 ++++++++++++++
 tb/tb_vga_pattern_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_ctrl.sv
// VGA timing generator with a registered test-pattern pixel path (solid, bars, checker, moving bar).
// Optional frame border: define VGA_BORDER_EN.
module vga_pattern_ctrl #(
  parameter int COLOR_W   = 4,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 4,
  parameter bit SYNC_POL  = 1'b0,
  parameter int CELL_LOG2 = 5,
  parameter int BAR_W     = 16,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int X_W      = $clog2(H_TOTAL),
  localparam int Y_W      = $clog2(V_TOTAL)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3*COLOR_W-1:0] sw,
  input  logic [1:0]           mode,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 video_on,
  output logic [X_W-1:0]       pix_x,
  output logic [Y_W-1:0]       pix_y,
  output logic [3*COLOR_W-1:0] rgb,
  output logic                 frame_start
);
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int BAR_PX   = H_ACTIVE / 8;

  logic [DIV_W-1:0]     div_q, div_d;
  logic [X_W-1:0]       hcnt_q, hcnt_d, pos_q, pos_d;
  logic [Y_W-1:0]       vcnt_q, vcnt_d;
  logic [1:0]           mode_q, mode_d;
  logic                 hsync_q, hsync_d, vsync_q, vsync_d, von_q, von_d, fs_q, fs_d;
  logic [X_W-1:0]       pix_x_q, pix_x_d;
  logic [Y_W-1:0]       pix_y_q, pix_y_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d, pat;

  logic           tick, h_last, v_last, active, in_bar, chk;
  logic [X_W-1:0] bar_k;
  logic [2:0]     bar_c;
  logic [X_W:0]   bar_end;

  always_comb begin
    tick   = (div_q == DIV_W'(CLK_DIV - 1));
    h_last = (int'(hcnt_q) == H_TOTAL - 1);
    v_last = (int'(vcnt_q) == V_TOTAL - 1);
    active = (int'(hcnt_q) < H_ACTIVE) && (int'(vcnt_q) < V_ACTIVE);

    div_d  = tick ? '0 : div_q + 1'b1;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    mode_d = mode_q;
    pos_d  = pos_q;
    if (tick) begin
      hcnt_d = h_last ? '0 : hcnt_q + 1'b1;
      if (h_last) vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
      // Mode and bar position only move on the last tick of a frame.
      if (h_last && v_last) begin
        mode_d = mode;
        pos_d  = (int'(pos_q) >= H_ACTIVE - BAR_W) ? '0 : pos_q + 1'b1;
      end
    end

    bar_k   = hcnt_q / X_W'(BAR_PX);
    bar_c   = (int'(bar_k) > 7) ? 3'd0 : ~bar_k[2:0];
    chk     = hcnt_q[CELL_LOG2] ^ vcnt_q[CELL_LOG2];
    bar_end = {1'b0, pos_q} + (X_W+1)'(BAR_W);
    in_bar  = (hcnt_q >= pos_q) && ({1'b0, hcnt_q} < bar_end);

    case (mode_q)
      2'd0:    pat = sw;
      2'd1:    pat = {{COLOR_W{bar_c[2]}}, {COLOR_W{bar_c[1]}}, {COLOR_W{bar_c[0]}}};
      2'd2:    pat = chk ? sw : '0;
      default: pat = in_bar ? sw : '0;
    endcase
`ifdef VGA_BORDER_EN
    if (hcnt_q == '0 || int'(hcnt_q) == H_ACTIVE - 1 ||
        vcnt_q == '0 || int'(vcnt_q) == V_ACTIVE - 1)
      pat = '1;
`endif

    hsync_d = hsync_q;
    vsync_d = vsync_q;
    von_d   = von_q;
    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    rgb_d   = rgb_q;
    fs_d    = 1'b0;
    if (tick) begin
      hsync_d = ((int'(hcnt_q) >= HS_START) && (int'(hcnt_q) < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_d = ((int'(vcnt_q) >= VS_START) && (int'(vcnt_q) < VS_END)) ? SYNC_POL : ~SYNC_POL;
      von_d   = active;
      pix_x_d = hcnt_q;
      pix_y_d = vcnt_q;
      rgb_d   = active ? pat : '0;
      fs_d    = (hcnt_q == '0) && (vcnt_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      mode_q  <= '0;
      pos_q   <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      von_q   <= 1'b0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      rgb_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      mode_q  <= mode_d;
      pos_q   <= pos_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      von_q   <= von_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      rgb_q   <= rgb_d;
      fs_q    <= fs_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = von_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign rgb         = rgb_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_pattern_ctrl.sv
// Directed bench for vga_pattern_ctrl on a shrunken 24x12 raster (16x8 active, 4 clks/pixel).
module tb_vga_pattern_ctrl;
  localparam int HT = 24, VT = 12, DIV = 4;
  localparam int FRAME = HT * VT * DIV;

  logic        clk = 1'b0, rst;
  logic [11:0] sw, rgb;
  logic [1:0]  mode;
  logic        hsync, vsync, video_on, frame_start;
  logic [4:0]  pix_x;
  logic [3:0]  pix_y;
  int          cyc = 0;
  int          checks = 0, errors = 0;

  vga_pattern_ctrl #(
    .COLOR_W(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(DIV), .SYNC_POL(1'b0), .CELL_LOG2(2), .BAR_W(4)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .mode(mode),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pix_x(pix_x), .pix_y(pix_y), .rgb(rgb), .frame_start(frame_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  mode;
    logic [11:0] sw;
    int          x, y;
    logic [11:0] rgb;
    logic        von, hs, vs;
  } vec_t;
  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic find_pix(input int x, input int y, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (int'(pix_x) == x && int'(pix_y) == y) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout($sformatf("find_pix(%0d,%0d)", x, y));
  endtask

  // which: 0=hsync 1=vsync 2=frame_start
  task automatic wait_sig(input int which, input logic val, output bit ok);
    logic s;
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      s = (which == 0) ? hsync : (which == 1) ? vsync : frame_start;
      if (s === val) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout($sformatf("wait_sig%0d=%0b", which, val));
  endtask

  initial begin
    bit ok;
    int first, width, t0, t1, t2, cur_mode, expos;

    // mode, sw, x, y, rgb, video_on, hsync, vsync
    vecs[0]  = '{2'd0, 12'hF0A,  0,  0, 12'hF0A, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{2'd0, 12'hF0A, 15,  7, 12'hF0A, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{2'd0, 12'hF0A, 16,  3, 12'h000, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{2'd0, 12'hF0A, 19,  3, 12'h000, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{2'd0, 12'hF0A,  5,  9, 12'h000, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{2'd0, 12'hF0A, 20, 10, 12'h000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{2'd0, 12'hF0A, 21, 11, 12'h000, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{2'd1, 12'hF0A,  0,  2, 12'hFFF, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{2'd1, 12'hF0A,  2,  2, 12'hFF0, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{2'd1, 12'hF0A, 15,  2, 12'h000, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{2'd1, 12'hF0A,  5,  2, 12'hF0F, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{2'd1, 12'hF0A,  8,  4, 12'h0FF, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{2'd2, 12'h5A3,  4,  0, 12'h5A3, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{2'd2, 12'h5A3,  4,  4, 12'h000, 1'b1, 1'b1, 1'b1};
    vecs[14] = '{2'd2, 12'h5A3,  0,  0, 12'h000, 1'b1, 1'b1, 1'b1};
    vecs[15] = '{2'd2, 12'h5A3,  9,  5, 12'h5A3, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; mode = 2'd0; sw = 12'hF0A;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_outputs", {hsync, vsync, video_on, frame_start, rgb},
          {1'b1, 1'b1, 1'b0, 1'b0, 12'h000});
    end
    rst = 1'b0;
    first = 0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (frame_start && first == 0) first = n;
    end
    chk("first_tick_clks", first, 4);

    // Sync widths and periods.
    wait_sig(0, 1'b1, ok); wait_sig(0, 1'b0, ok); t0 = cyc;
    wait_sig(0, 1'b1, ok); t1 = cyc; wait_sig(0, 1'b0, ok); t2 = cyc;
    chk("hsync_low_clks", t1 - t0, 3 * DIV);
    chk("hsync_period", t2 - t0, HT * DIV);
    wait_sig(1, 1'b1, ok); wait_sig(1, 1'b0, ok); t0 = cyc;
    wait_sig(1, 1'b1, ok); t1 = cyc; wait_sig(1, 1'b0, ok); t2 = cyc;
    chk("vsync_low_clks", t1 - t0, 2 * HT * DIV);
    chk("vsync_period", t2 - t0, FRAME);
    wait_sig(2, 1'b1, ok); t0 = cyc; wait_sig(2, 1'b0, ok);
    chk("frame_start_width", cyc - t0, 1);
    wait_sig(2, 1'b1, ok);
    chk("frame_start_period", cyc - t0, FRAME);

    cur_mode = 0;
    for (int i = 0; i < 16; i++) begin
      mode = vecs[i].mode;
      sw   = vecs[i].sw;
      if (int'(vecs[i].mode) != cur_mode) begin
        wait_sig(2, 1'b1, ok); wait_sig(2, 1'b0, ok); wait_sig(2, 1'b1, ok);
        cur_mode = int'(vecs[i].mode);
      end
      find_pix(vecs[i].x, vecs[i].y, ok);
      chk($sformatf("vec%0d_rgb", i), rgb, vecs[i].rgb);
      chk($sformatf("vec%0d_von_hs_vs", i), {video_on, hsync, vsync},
          {vecs[i].von, vecs[i].hs, vecs[i].vs});
    end

    // Mode change mid-frame waits for the frame boundary.
    mode = 2'd0; sw = 12'hF0A;
    wait_sig(2, 1'b1, ok); wait_sig(2, 1'b0, ok); wait_sig(2, 1'b1, ok);
    find_pix(0, 4, ok);
    mode = 2'd2;
    find_pix(5, 6, ok);
    chk("deferred_same_frame", rgb, 12'hF0A);
    wait_sig(2, 1'b1, ok);
    find_pix(4, 0, ok);
    chk("deferred_next_4_0", rgb, 12'hF0A);
    find_pix(4, 4, ok);
    chk("deferred_next_4_4", rgb, 12'h000);

    // Mode present only during the final tick's cycle is still captured.
    find_pix(22, 11, ok);
    repeat (3) @(negedge clk);
    mode = 2'd1;
    @(negedge clk);
    mode = 2'd2;
    find_pix(0, 2, ok);
    chk("final_tick_capture", rgb, 12'hFFF);

    // Reset mid-frame: timing and mode restart.
    find_pix(0, 5, ok);
    rst = 1'b1; mode = 2'd2;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    first = 0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (frame_start && first == 0) begin
        first = n;
        t0 = cyc;
      end
    end
    chk("midreset_first_tick", first, 4);
    find_pix(4, 4, ok);
    chk("midreset_mode_cleared", rgb, 12'hF0A);
    wait_sig(2, 1'b1, ok);
    chk("midreset_frame_period", cyc - t0, FRAME);

    // Moving bar: frame k after reset has pos=k, wrapping to 0 after 12.
    mode = 2'd3; sw = 12'hFFF;
    wait_sig(2, 1'b0, ok);
    for (int k = 2; k <= 15; k++) begin
      wait_sig(2, 1'b1, ok);
      first = -1; width = 0;
      for (int p = 0; p < 16; p++) begin
        if (rgb != 12'h000) begin
          if (first < 0) first = int'(pix_x);
          width++;
        end
        repeat (DIV) @(negedge clk);
      end
      expos = (k <= 12) ? k : k - 13;
      chk($sformatf("bar_pos_frame%0d", k), first, expos);
      chk($sformatf("bar_width_frame%0d", k), width, 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
